// File: rtl/video_timing.sv
// Video raster timing generator: pixel-rate divider, x/y counters and registered sync/blank outputs.
// Define VIDEO_TIMING_FRAMECOUNT_EN to add the 16-bit frame_count output.
module video_timing #(
    parameter int CLKDIV   = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        reset_in,
    input  logic        enable,
    input  logic        restart,
    output logic        pixel,
    output logic        hs,
    output logic        vs,
    output logic        vena,
    output logic        hblank,
    output logic        vblank,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        line_start,
`ifdef VIDEO_TIMING_FRAMECOUNT_EN
    output logic [15:0] frame_count,
`endif
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    if (CLKDIV < 1 || CLKDIV > 16) begin : g_bad_clkdiv
        $error("video_timing: CLKDIV must be 1..16");
    end
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 || H_TOTAL > 4096) begin : g_bad_h
        $error("video_timing: horizontal widths must be >= 1 with total <= 4096");
    end
    if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || V_TOTAL > 4096) begin : g_bad_v
        $error("video_timing: vertical widths must be >= 1 with total <= 4096");
    end

    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
    localparam logic [11:0]   H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0]   V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0]   H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0]   V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0]   HS_FIRST = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0]   HS_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0]   VS_FIRST = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0]   VS_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DW-1:0] div_q;
    logic          tick;
    logic [11:0]   x_nxt;
    logic [11:0]   y_nxt;
    logic          ls_q;
    logic          fs_q;

    // A pixel clk is the last divider phase of an enabled, non-restarting cycle.
    assign tick  = enable && !restart && (div_q == DIV_LAST);
    assign pixel = tick;

    always_comb begin
        x_nxt = (xpos == H_LAST) ? 12'd0 : xpos + 12'd1;
        y_nxt = ypos;
        if (xpos == H_LAST) begin
            y_nxt = (ypos == V_LAST) ? 12'd0 : ypos + 12'd1;
        end
    end

    // The one-clk pulses must not appear while timing is frozen.
    assign line_start  = ls_q && enable;
    assign frame_start = fs_q && enable;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            div_q  <= '0;
            xpos   <= H_LAST;
            ypos   <= V_LAST;
            hs     <= !HS_POL;
            vs     <= !VS_POL;
            hblank <= 1'b1;
            vblank <= 1'b1;
            vena   <= 1'b0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else if (restart) begin
            div_q  <= '0;
            xpos   <= H_LAST;
            ypos   <= V_LAST;
            hs     <= !HS_POL;
            vs     <= !VS_POL;
            hblank <= 1'b1;
            vblank <= 1'b1;
            vena   <= 1'b0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else if (enable) begin
            div_q <= tick ? '0 : div_q + 1'b1;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
            if (tick) begin
                // Level outputs are decoded from the next position so they line up with xpos/ypos.
                xpos   <= x_nxt;
                ypos   <= y_nxt;
                hs     <= (x_nxt >= HS_FIRST && x_nxt <= HS_LAST) ? HS_POL : !HS_POL;
                vs     <= (y_nxt >= VS_FIRST && y_nxt <= VS_LAST) ? VS_POL : !VS_POL;
                hblank <= (x_nxt >= H_ACT);
                vblank <= (y_nxt >= V_ACT);
                vena   <= (x_nxt < H_ACT) && (y_nxt < V_ACT);
                ls_q   <= (x_nxt == 12'd0);
                fs_q   <= (x_nxt == 12'd0) && (y_nxt == 12'd0);
            end
        end else begin
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end
    end

`ifdef VIDEO_TIMING_FRAMECOUNT_EN
    // Counts frames across restarts; only reset clears it.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            frame_count <= 16'd0;
        end else if (tick && x_nxt == 12'd0 && y_nxt == 12'd0) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_video_timing.sv
// Self-checking bench for video_timing: a reference raster model feeds a scoreboard queue
// that is compared against the DUT every clk, plus directed boundary checks.
module tb_video_timing;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        hs;
        logic        vs;
        logic        vena;
        logic        hb;
        logic        vb;
        logic        pixel;
        logic        ls;
        logic        fs;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        enable;
    logic        restart;
    logic        pixel, hs, vs, vena, hblank, vblank, line_start, frame_start;
    logic [11:0] xpos, ypos;
`ifdef VIDEO_TIMING_FRAMECOUNT_EN
    logic [15:0] frame_count;
`endif

    int checks = 0;
    int errors = 0;

    video_timing #(
        .CLKDIV(2),
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0)
    ) dut (
        .clk(clk),
        .reset_in(reset_in),
        .enable(enable),
        .restart(restart),
        .pixel(pixel),
        .hs(hs),
        .vs(vs),
        .vena(vena),
        .hblank(hblank),
        .vblank(vblank),
        .xpos(xpos),
        .ypos(ypos),
        .line_start(line_start),
`ifdef VIDEO_TIMING_FRAMECOUNT_EN
        .frame_count(frame_count),
`endif
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Reference model state: divider phase, raster position, pulses pending in the current clk.
    int   md, mx, my;
    logic m_ls, m_fs;
    obs_t exp_q[$];
    int   cyc;
    int   fs_cycles[$];
    int   vena_pix, hs_pix, vs_low_pix;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic obs_t model_out();
        obs_t e;
        e.x     = 12'(mx);
        e.y     = 12'(my);
        e.hs    = (mx >= 5 && mx <= 6);
        e.vs    = (my != 4);
        e.hb    = (mx >= 4);
        e.vb    = (my >= 3);
        e.vena  = !e.hb && !e.vb;
        e.pixel = reset_in && enable && !restart && (md == 1);
        e.ls    = m_ls && enable;
        e.fs    = m_fs && enable;
        return e;
    endfunction

    function automatic obs_t sample();
        return '{xpos, ypos, hs, vs, vena, hblank, vblank, pixel, line_start, frame_start};
    endfunction

    task automatic model_reset();
        md = 0; mx = 7; my = 5; m_ls = 1'b0; m_fs = 1'b0;
    endtask

    task automatic model_advance();
        logic pix;
        pix  = (md == 1);
        m_ls = 1'b0;
        m_fs = 1'b0;
        if (!reset_in || restart) begin
            model_reset();
        end else if (enable) begin
            md = pix ? 0 : md + 1;
            if (pix) begin
                if (mx == 7) begin
                    mx = 0;
                    my = (my == 5) ? 0 : my + 1;
                end else begin
                    mx = mx + 1;
                end
                m_ls = (mx == 0);
                m_fs = (mx == 0) && (my == 0);
            end
        end
    endtask

    // One clk: push the expectation for the current inputs, compare, advance the model, cross the edge.
    task automatic step(input string tag);
        obs_t o;
        obs_t e;
        #1;
        exp_q.push_back(model_out());
        o = sample();
        e = exp_q.pop_front();
        check(tag, 64'(o), 64'(e));
        if (o.fs) fs_cycles.push_back(cyc);
        if (cyc >= 2 && cyc <= 97 && o.pixel) begin
            if (o.vena) vena_pix++;
            if (o.hs)   hs_pix++;
            if (!o.vs)  vs_low_pix++;
        end
        cyc++;
        model_advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        obs_t o;
        obs_t e;
        int   n;
        reset_in = 1'b0;
        enable   = 1'b0;
        restart  = 1'b0;
        model_reset();
        cyc = -100;
        vena_pix = 0; hs_pix = 0; vs_low_pix = 0;
        @(posedge clk);
        #1;
        repeat (3) step("reset_state");

        // Free run for two full frames after release.
        reset_in = 1'b1;
        enable   = 1'b1;
        cyc      = 0;
        repeat (196) step("free_run");
        check("first_frame_start_clk", 64'(fs_cycles.size() > 0 ? fs_cycles[0] : -1), 64'(2));
        check("frame_start_period", 64'(fs_cycles.size() > 1 ? fs_cycles[1] - fs_cycles[0] : -1), 64'(96));
        check("vena_pixels_per_frame", 64'(vena_pix), 64'(12));
        check("hs_pixels_per_frame", 64'(hs_pix), 64'(12));
        check("vs_low_pixels_per_frame", 64'(vs_low_pix), 64'(8));

        // Freeze at xpos=3 for 7 clks.
        n = 0;
        while (!(mx == 3 && md == 0) && n < 200) begin step("seek_x3"); n++; end
        check("seek_x3_reached", 64'(n < 200), 64'(1));
        enable = 1'b0;
        o = sample();
        repeat (7) step("frozen");
        e = sample();
        check("frozen_outputs_held", 64'(e), 64'(o));
        enable = 1'b1;
        repeat (2) step("resume");
        check("resume_xpos", 64'(xpos), 64'(4));

        // Restart at xpos=5, ypos=2 with enable low.
        n = 0;
        while (!(mx == 5 && my == 2 && md == 0) && n < 200) begin step("seek_x5y2"); n++; end
        check("seek_x5y2_reached", 64'(n < 200), 64'(1));
        enable  = 1'b0;
        restart = 1'b1;
        step("restart");
        restart = 1'b0;
        check("restart_pos_sync", 64'({xpos, ypos, hs, vs}), 64'({12'd7, 12'd5, 1'b0, 1'b1}));
        enable = 1'b1;
        n = fs_cycles.size();
        repeat (4) step("after_restart");
        check("restart_frame_start_count", 64'(fs_cycles.size() - n), 64'(1));

        // Asynchronous reset mid-line at xpos=2.
        n = 0;
        while (!(mx == 2 && md == 0) && n < 200) begin step("seek_x2"); n++; end
        check("seek_x2_reached", 64'(n < 200), 64'(1));
        #2;
        reset_in = 1'b0;
        #1;
        model_reset();
        exp_q.push_back(model_out());
        o = sample();
        e = exp_q.pop_front();
        check("async_reset", 64'(o), 64'(e));
        @(posedge clk);
        #1;
        step("held_in_reset");

`ifdef VIDEO_TIMING_FRAMECOUNT_EN
        reset_in = 1'b1;
        enable   = 1'b1;
        dut.frame_count = 16'hFFFE;
        n = 0;
        while (!frame_start && n < 200) begin step("fc_seek1"); n++; end
        check("frame_count_first", 64'(frame_count), 64'(16'hFFFF));
        step("fc_gap");
        n = 0;
        while (!frame_start && n < 200) begin step("fc_seek2"); n++; end
        check("frame_count_wrap", 64'(frame_count), 64'(16'h0000));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 SHALL provide parameter CLKDIV, default 4: clk cycles per pixel, range 1..16.
REQ-002 SHALL provide parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal widths in pixels.
REQ-003 SHALL provide parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical widths in lines.
REQ-004 SHALL provide parameters HS_POL/VS_POL, defaults 0/0: asserted sync level (0 = active-low).
REQ-005 SHALL provide ports:
- clk  in  1  sole clock.
- reset_in  in  1  asynchronous, active-low reset.
- enable  in  1  advance timing when high.
- restart  in  1  synchronous resync to frame start.
- pixel  out  1  one-clk pixel enable.
- hs  out  1  horizontal sync.
- vs  out  1  vertical sync.
- vena  out  1  active video.
- hblank  out  1  horizontal blanking.
- vblank  out  1  vertical blanking.
- xpos  out  12  horizontal counter.
- ypos  out  12  vertical counter.
- line_start  out  1  first pixel of line.
- frame_start  out  1  first pixel of frame.

Function
REQ-006 H_TOTAL = sum of H widths, V_TOTAL = sum of V widths; each width >= 1 and each total <= 4096, else elaboration SHALL fail.
REQ-007 Divider counts 0..CLKDIV-1 while enable=1 and restart=0; pixel SHALL be 1 for exactly the clk in which divider = CLKDIV-1 (CLKDIV=1: pixel=1 every enabled clk).
REQ-008 On each pixel clk, xpos SHALL increment at the next edge; xpos = H_TOTAL-1 wraps to 0 and advances ypos; ypos = V_TOTAL-1 wraps to 0.
REQ-009 All outputs SHALL be registered and, other than pixel, change only on the edge ending a pixel clk.
REQ-010 Per line: active 0..H_ACTIVE-1, then front porch, sync, back porch; hs = HS_POL iff xpos in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else !HS_POL.
REQ-011 Vertically identical on ypos with V_* and VS_POL; vs SHALL change only on the same edge as ypos.
REQ-012 hblank = (xpos >= H_ACTIVE); vblank = (ypos >= V_ACTIVE); vena = !hblank && !vblank.
REQ-013 line_start SHALL be 1 for one clk while xpos = 0, on the first clk after xpos becomes 0; frame_start likewise when xpos = 0 and ypos = 0.
REQ-014 enable=0 SHALL freeze divider, counters and all level outputs; pixel, line_start and frame_start SHALL be 0.
REQ-015 restart=1 SHALL load divider=0, xpos=H_TOTAL-1, ypos=V_TOTAL-1 and set outputs to reset values at the next edge; restart overrides enable.

Reset
REQ-016 reset_in=0 SHALL asynchronously set divider=0, xpos=H_TOTAL-1, ypos=V_TOTAL-1, hs=!HS_POL, vs=!VS_POL, hblank=vblank=1, vena=0, pixel=line_start=frame_start=0.
REQ-017 Reset mid-frame SHALL abandon the frame; after release, the first pixel clk SHALL wrap to (0,0) and pulse frame_start.

Configuration
REQ-018 With VIDEO_TIMING_FRAMECOUNT_EN defined, port frame_count (out, 16) SHALL exist, reset to 0, increment on each frame_start, and wrap 0xFFFF->0; restart SHALL not clear it.
REQ-019 Without VIDEO_TIMING_FRAMECOUNT_EN, frame_count and its logic SHALL be absent; all other behaviour unchanged.

Verification
Bench parameters: CLKDIV=2; H 4/1/2/1 (H_TOTAL=8); V 3/1/1/1 (V_TOTAL=6); HS_POL=1; VS_POL=0.
REQ-020 Release reset, enable=1 -> pixel every 2nd clk; frame_start pulses at clk 2 and every 96 clks after; xpos follows 0..7.
REQ-021 Full frame -> hs=1 exactly for xpos 5..6; vs=0 exactly for ypos 4; vena=1 for 12 pixels per frame.
REQ-022 enable=0 for 7 clks at xpos=3 -> all outputs held, pixel=0; resumes with xpos=4.
REQ-023 restart=1 at xpos=5, ypos=2 with enable=0 -> next edge xpos=7, ypos=5, hs=0, vs=1; frame_start after first pixel.
REQ-024 reset_in=0 mid-line at xpos=2 -> outputs immediately at REQ-016 values, without clk edge.
REQ-025 With VIDEO_TIMING_FRAMECOUNT_EN, preload 0xFFFE, run 2 frames -> frame_count = 0xFFFF then 0x0000.
